usb_ep_echo_consumer: RTL and testbench

Endpoint-side counterpart of the device's endpoint FIFO interface: drains one complete host-to-device packet from the EP IN pop interface into a local buffer, then writes the same bytes back through the EP OUT fill interface for the host to read. It sits between `top`'s endpoint ports and nothing else, in the `clk12_o` domain. It serves as a loopback function for simulation and for hardware bring-up. It serves a single endpoint, EP01 (lane 0 of the endpoint vectors).

---
 rtl/usb_ep_echo_consumer.sv | 155 +++++++++++++++
 tb/tb_usb_ep_echo_consumer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_echo_consumer.sv
// EP01 loopback: drains one host-to-device packet from the EP IN pop port into a
// local buffer, then replays it through the EP OUT fill port with abort/backoff retry.
module usb_ep_echo_consumer #(
  parameter  int MAX_PACKET_BYTES = 64,
  parameter  int RETRY_DELAY      = 16,
  localparam int CNT_W            = $clog2(MAX_PACKET_BYTES + 1)
) (
  input  logic        clk12_i,
  input  logic        rst_i,
  input  logic        EP_IN_dataAvailable_i,
  input  logic [7:0]  EP_IN_data_i,
  output logic        EP_IN_popData_o,
  output logic        EP_IN_popTransDone_o,
  output logic        EP_IN_popTransSuccess_o,
  input  logic        EP_OUT_full_i,
  output logic        EP_OUT_dataValid_o,
  output logic [7:0]  EP_OUT_data_o,
  output logic        EP_OUT_fillTransDone_o,
  output logic        EP_OUT_fillTransSuccess_o,
  output logic        busy_o,
  output logic [15:0] echoCount_o
);

  localparam int ADDR_W = (MAX_PACKET_BYTES > 1) ? $clog2(MAX_PACKET_BYTES) : 1;
  localparam int BO_W   = (RETRY_DELAY > 0) ? $clog2(RETRY_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, DRAIN, IN_COMMIT, FILL, OUT_COMMIT, OUT_ABORT, BACKOFF
  } state_t;

  state_t            state_r, nextState_s;
  logic [CNT_W-1:0]  len_r, idx_r;
  logic [BO_W-1:0]   backoff_r;
  logic [15:0]       echoCount_r;
  logic [7:0]        bufMem_r [0:MAX_PACKET_BYTES-1];

  logic popData_s, popDone_s, popOk_s;
  logic dataValid_s, fillDone_s, fillOk_s;
  logic lenFull_s, lastByte_s;

  assign lenFull_s  = (len_r == CNT_W'(MAX_PACKET_BYTES));
  assign lastByte_s = (idx_r == (len_r - CNT_W'(1)));

  // Next-state and handshake strobe decode
  always_comb begin
    nextState_s = state_r;
    popData_s   = 1'b0;
    popDone_s   = 1'b0;
    popOk_s     = 1'b0;
    dataValid_s = 1'b0;
    fillDone_s  = 1'b0;
    fillOk_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (EP_IN_dataAvailable_i) nextState_s = DRAIN;
        else                       nextState_s = IDLE;
      end
      DRAIN: begin
        if (!EP_IN_dataAvailable_i) begin
          nextState_s = IN_COMMIT;
        end else if (lenFull_s) begin
          // Oversized packet: roll the pops back and drop it
          popDone_s   = 1'b1;
          nextState_s = IDLE;
        end else begin
          popData_s   = 1'b1;
          nextState_s = DRAIN;
        end
      end
      IN_COMMIT: begin
        popDone_s   = 1'b1;
        popOk_s     = 1'b1;
        nextState_s = FILL;
      end
      FILL: begin
        if (EP_OUT_full_i) begin
          nextState_s = OUT_ABORT;
        end else begin
          dataValid_s = 1'b1;
          if (lastByte_s) nextState_s = OUT_COMMIT;
          else            nextState_s = FILL;
        end
      end
      OUT_COMMIT: begin
        fillDone_s  = 1'b1;
        fillOk_s    = 1'b1;
        nextState_s = IDLE;
      end
      OUT_ABORT: begin
        fillDone_s  = 1'b1;
        nextState_s = BACKOFF;
      end
      BACKOFF: begin
        // Counter reaches zero on the same edge FILL is re-entered
        if (backoff_r <= BO_W'(1)) nextState_s = FILL;
        else                       nextState_s = BACKOFF;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State, counters and echo statistics
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      len_r       <= CNT_W'(0);
      idx_r       <= CNT_W'(0);
      backoff_r   <= BO_W'(0);
      echoCount_r <= 16'd0;
    end else begin
      state_r <= nextState_s;
      case (state_r)
        IDLE: len_r <= CNT_W'(0);
        DRAIN: begin
          if (popData_s)      len_r <= len_r + CNT_W'(1);
          else if (popDone_s) len_r <= CNT_W'(0);
          else                len_r <= len_r;
        end
        IN_COMMIT: idx_r <= CNT_W'(0);
        FILL: begin
          if (dataValid_s) idx_r <= idx_r + CNT_W'(1);
          else             idx_r <= idx_r;
        end
        OUT_COMMIT: begin
          echoCount_r <= echoCount_r + 16'd1;
          len_r       <= CNT_W'(0);
        end
        OUT_ABORT: backoff_r <= BO_W'(RETRY_DELAY);
        BACKOFF: begin
          if (backoff_r != BO_W'(0)) backoff_r <= backoff_r - BO_W'(1);
          else                       backoff_r <= backoff_r;
          if (nextState_s == FILL)   idx_r <= CNT_W'(0);
          else                       idx_r <= idx_r;
        end
        default: state_r <= nextState_s;
      endcase
    end
  end

  // Packet buffer; contents survive aborts so retries replay the same bytes
  always_ff @(posedge clk12_i) begin
    if (popData_s) bufMem_r[len_r[ADDR_W-1:0]] <= EP_IN_data_i;
  end

  assign EP_IN_popData_o           = popData_s;
  assign EP_IN_popTransDone_o      = popDone_s;
  assign EP_IN_popTransSuccess_o   = popOk_s;
  assign EP_OUT_dataValid_o        = dataValid_s;
  assign EP_OUT_data_o             = (state_r == FILL) ? bufMem_r[idx_r[ADDR_W-1:0]] : 8'h00;
  assign EP_OUT_fillTransDone_o    = fillDone_s;
  assign EP_OUT_fillTransSuccess_o = fillOk_s;
  assign busy_o                    = (state_r != IDLE);
  assign echoCount_o               = echoCount_r;

endmodule

// File: tb/tb_usb_ep_echo_consumer.sv
// Directed bench for usb_ep_echo_consumer: models the EP IN FIFO head and records
// the EP OUT stream, then compares against hand-computed expectations.
module tb_usb_ep_echo_consumer;

  logic        clk = 1'b0;
  logic        rst;
  logic        avail = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        full = 1'b0;
  logic        popData, popDone, popSucc;
  logic        dataValid, fillDone, fillSucc, busy;
  logic [7:0]  outData;
  logic [15:0] echoCount;

  always #5 clk = ~clk;

  usb_ep_echo_consumer dut (
    .clk12_i                  (clk),
    .rst_i                    (rst),
    .EP_IN_dataAvailable_i    (avail),
    .EP_IN_data_i             (inData),
    .EP_IN_popData_o          (popData),
    .EP_IN_popTransDone_o     (popDone),
    .EP_IN_popTransSuccess_o  (popSucc),
    .EP_OUT_full_i            (full),
    .EP_OUT_dataValid_o       (dataValid),
    .EP_OUT_data_o            (outData),
    .EP_OUT_fillTransDone_o   (fillDone),
    .EP_OUT_fillTransSuccess_o(fillSucc),
    .busy_o                   (busy),
    .echoCount_o              (echoCount)
  );

  logic [7:0] inQ [$];
  logic [7:0] outQ [$];
  int cyc = 0, popCnt = 0, popOk = 0, popFail = 0, fillOk = 0, fillFail = 0;
  int riseCyc = 0, doneCyc = 0, failCyc = 0, retryCyc = 0, fullAtSize = 2;
  bit doPop = 1'b0, flushIn = 1'b0, fullArm = 1'b0, waitingRetry = 1'b0, availPrev = 1'b0;
  int passCnt = 0, totalCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // IN FIFO model and OUT-side monitor: sample at negedge, update inputs after posedge
  always begin
    @(negedge clk);
    cyc++;
    doPop = popData;
    if (popData) popCnt++;
    if (dataValid) begin
      outQ.push_back(outData);
      if (waitingRetry) begin
        retryCyc = cyc;
        waitingRetry = 1'b0;
      end
    end
    if (popDone) begin
      if (popSucc) popOk++;
      else begin
        popFail++;
        flushIn = 1'b1;
      end
    end
    if (fillDone) begin
      if (fillSucc) begin
        fillOk++;
        doneCyc = cyc;
      end else begin
        fillFail++;
        failCyc = cyc;
        waitingRetry = 1'b1;
        fullArm = 1'b0;
      end
    end
    if (avail && !availPrev) riseCyc = cyc;
    availPrev = avail;
    @(posedge clk);
    #1;
    if (doPop && inQ.size() > 0) void'(inQ.pop_front());
    if (flushIn) begin
      inQ.delete();
      flushIn = 1'b0;
    end
    avail  = (inQ.size() > 0);
    inData = (inQ.size() > 0) ? inQ[0] : 8'h00;
    full   = fullArm && (outQ.size() == fullAtSize);
  end

  task automatic clearStats();
    outQ.delete();
    popCnt = 0; popOk = 0; popFail = 0; fillOk = 0; fillFail = 0;
  endtask

  task automatic waitIdle(input string tag, input int maxCyc);
    bit done;
    done = 1'b0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < maxCyc && !done; n++) begin
      @(negedge clk);
      #1;
      if (!busy && inQ.size() == 0) done = 1'b1;
    end
    checkVal({tag, "_idle"}, done, 1'b1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, "_pop"},      popData,   1'b0);
    checkVal({tag, "_popDone"},  popDone,   1'b0);
    checkVal({tag, "_valid"},    dataValid, 1'b0);
    checkVal({tag, "_fillDone"}, fillDone,  1'b0);
    checkVal({tag, "_busy"},     busy,      1'b0);
  endtask

  int errs;
  bit seen;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkIdleOutputs("rst");
    checkVal("rst_count", echoCount, 16'h0000);
    rst = 1'b0;

    // Reset during FILL of a 4-byte echo
    clearStats();
    inQ.push_back(8'h11); inQ.push_back(8'h22); inQ.push_back(8'h33); inQ.push_back(8'h44);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk); #1;
      if (outQ.size() >= 2) seen = 1'b1;
    end
    checkVal("midfill_reached", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    checkIdleOutputs("midrst");
    checkVal("midrst_count", echoCount, 16'h0000);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkVal("midrst_noDone", fillOk + fillFail, 0);

    // 3-byte packet, no stalls
    clearStats();
    inQ.push_back(8'hA1); inQ.push_back(8'hB2); inQ.push_back(8'hC3);
    waitIdle("p3", 60);
    checkVal("p3_pops", popCnt, 3);
    checkVal("p3_popOk", popOk, 1);
    checkVal("p3_outLen", outQ.size(), 3);
    if (outQ.size() == 3) begin
      checkVal("p3_b0", outQ[0], 8'hA1);
      checkVal("p3_b1", outQ[1], 8'hB2);
      checkVal("p3_b2", outQ[2], 8'hC3);
    end
    checkVal("p3_fillOk", fillOk, 1);
    checkVal("p3_latency", doneCyc - riseCyc, 9);
    checkVal("p3_count", echoCount, 16'd1);

    // Maximum-size 64-byte packet
    clearStats();
    for (int i = 0; i < 64; i++) inQ.push_back(8'(i));
    waitIdle("p64", 300);
    checkVal("p64_pops", popCnt, 64);
    checkVal("p64_outLen", outQ.size(), 64);
    errs = 0;
    for (int i = 0; i < outQ.size(); i++) if (outQ[i] !== 8'(i)) errs++;
    checkVal("p64_dataErrs", errs, 0);
    checkVal("p64_count", echoCount, 16'd2);

    // 65-byte packet overflows and is dropped
    clearStats();
    for (int i = 0; i < 65; i++) inQ.push_back(8'(8'h80 + i));
    waitIdle("p65", 300);
    checkVal("p65_pops", popCnt, 64);
    checkVal("p65_popFail", popFail, 1);
    checkVal("p65_popOk", popOk, 0);
    checkVal("p65_outLen", outQ.size(), 0);
    checkVal("p65_fill", fillOk + fillFail, 0);
    checkVal("p65_count", echoCount, 16'd2);

    // Next packet after overflow echoes normally
    clearStats();
    inQ.push_back(8'h5A); inQ.push_back(8'h3C);
    waitIdle("p2", 60);
    checkVal("p2_outLen", outQ.size(), 2);
    if (outQ.size() == 2) begin
      checkVal("p2_b0", outQ[0], 8'h5A);
      checkVal("p2_b1", outQ[1], 8'h3C);
    end
    checkVal("p2_count", echoCount, 16'd3);

    // 5-byte packet with full on the 3rd fill cycle
    clearStats();
    fullAtSize = 2;
    fullArm = 1'b1;
    for (int i = 0; i < 5; i++) inQ.push_back(8'(8'h41 + i));
    waitIdle("p5", 120);
    checkVal("p5_fillFail", fillFail, 1);
    checkVal("p5_fillOk", fillOk, 1);
    checkVal("p5_backoffGap", retryCyc - failCyc - 1, 16);
    checkVal("p5_outLen", outQ.size(), 7);
    errs = 0;
    if (outQ.size() == 7) begin
      if (outQ[0] !== 8'h41 || outQ[1] !== 8'h42) errs++;
      for (int i = 0; i < 5; i++) if (outQ[2 + i] !== 8'(8'h41 + i)) errs++;
    end
    checkVal("p5_dataErrs", errs, 0);
    checkVal("p5_count", echoCount, 16'd4);

    // Counter wrap from 0xFFFF
    @(negedge clk); #1;
    force dut.echoCount_r = 16'hFFFF;
    @(negedge clk); #1;
    release dut.echoCount_r;
    @(negedge clk); #1;
    checkVal("wrap_preload", echoCount, 16'hFFFF);
    clearStats();
    inQ.push_back(8'h77);
    waitIdle("wrap", 40);
    checkVal("wrap_byte", (outQ.size() == 1) ? outQ[0] : 8'h00, 8'h77);
    checkVal("wrap_count", echoCount, 16'h0000);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
